// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral: oversampled SPI pins, write frames into NUM_REGS x DATA_W registers.
// Optional read-back over cipo is built when SPI_READBACK_EN is defined.
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [1:0]              ncs_sync_r;
    logic [1:0]              copi_sync_r;
    logic [2:0]              sclk_sync_r;
    logic                    ncs_s;
    logic                    copi_s;
    logic                    sclk_rise_s;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [FRAME_W-2:0]      shreg_r;
    logic [FRAME_W-2:0]      shreg_nxt_s;
    logic [FRAME_W-1:0]      frame_s;
    logic                    commit_s;
    logic                    abort_s;
    logic [ADDR_W-1:0]       frame_addr_s;
    logic [DATA_W-1:0]       frame_data_s;
    logic                    do_write_s;

    logic [DATA_W-1:0]       reg_mem_r [NUM_REGS];
    logic                    wr_strobe_r;
    logic                    frame_err_r;
    logic [ADDR_W-1:0]       wr_addr_r;

    // Pin synchronisers; ncs resets to its inactive (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_r  <= 2'b11;
            copi_sync_r <= 2'b00;
            sclk_sync_r <= 3'b000;
        end else begin
            ncs_sync_r  <= {ncs_sync_r[0], ncs};
            copi_sync_r <= {copi_sync_r[0], copi};
            sclk_sync_r <= {sclk_sync_r[1:0], sclk};
        end
    end

    assign ncs_s       = ncs_sync_r[1];
    assign copi_s      = copi_sync_r[1];
    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];

    // Completing rise must use the incoming bit, so decode from the shifted view
    assign frame_s      = {shreg_r, copi_s};
    assign frame_addr_s = frame_s[FRAME_W-2 -: ADDR_W];
    assign frame_data_s = frame_s[DATA_W-1:0];
    assign do_write_s   = commit_s & frame_s[FRAME_W-1] & ({1'b0, frame_addr_s} < NUM_REGS_L);

    // Frame FSM next-state, bit counter and shift register
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shreg_nxt_s = shreg_r;
        commit_s    = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!ncs_s) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = '0;
                    shreg_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ncs_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = (cnt_r != '0);
                end else if (sclk_rise_s) begin
                    shreg_nxt_s = frame_s[FRAME_W-2:0];
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s = ST_DONE;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (ncs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            shreg_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shreg_r <= shreg_nxt_s;
        end
    end

    // Register bank, write address and single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_mem_r[i] <= '0;
            end
            wr_addr_r   <= '0;
            wr_strobe_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_write_s && (frame_addr_s == ADDR_W'(i))) begin
                    reg_mem_r[i] <= frame_data_s;
                end
            end
            if (do_write_s) begin
                wr_addr_r <= frame_addr_s;
            end
            wr_strobe_r <= do_write_s;
            frame_err_r <= abort_s;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = reg_mem_r[g];
    end

    assign wr_strobe = wr_strobe_r;
    assign frame_err = frame_err_r;
    assign wr_addr   = wr_addr_r;

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] ADDR_END_CNT = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_MSB_CNT = CNT_W'(ADDR_W + 2);

    logic                sclk_fall_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                rd_load_s;
    logic                rd_shift_s;
    logic [DATA_W-1:0]   out_sh_r;
    logic                cipo_oe_r;

    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign rd_addr_s   = frame_s[ADDR_W-1:0];
    assign rd_load_s   = (state_r == ST_SHIFT) & ~ncs_s & sclk_rise_s &
                         (cnt_r == ADDR_END_CNT) & ~frame_s[ADDR_W];
    // The fall before the data-MSB rise must not shift, or the MSB is lost
    assign rd_shift_s  = (state_r == ST_SHIFT) & ~ncs_s & sclk_fall_s & (cnt_r >= DATA_MSB_CNT);

    // Read mux; out-of-range addresses return zero
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (rd_addr_s == ADDR_W'(i)) ? reg_mem_r[i] : rd_data_s;
        end
    end

    // Output shifter, held clear whenever the pad is not driven
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sh_r  <= '0;
            cipo_oe_r <= 1'b0;
        end else begin
            cipo_oe_r <= (state_nxt_s != ST_IDLE);
            if ((state_nxt_s == ST_IDLE) || (state_r == ST_IDLE)) begin
                out_sh_r <= '0;
            end else if (rd_load_s) begin
                out_sh_r <= rd_data_s;
            end else if (rd_shift_s) begin
                out_sh_r <= out_sh_r << 1;
            end else begin
                out_sh_r <= out_sh_r;
            end
        end
    end

    assign cipo    = out_sh_r[DATA_W-1];
    assign cipo_oe = cipo_oe_r;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral that exposes a bank of `NUM_REGS` configuration registers of `DATA_W` bits to an external controller, with write and optional read-back. It replaces the fixed five-register, write-only SPI front end and feeds the output-enable, PWM-enable and duty-cycle logic through a flat register bus. All SPI pins are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `NUM_REGS`, 5, number of implemented registers (1..2^`ADDR_W`)
- `DATA_W`, 8, register width in bits (≥1)
- `ADDR_W`, 7, address field width in bits (≥1)

Ports:
- `clk`  in  1  peripheral clock
- `rst_n`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI serial clock, async
- `ncs`  in  1  active-low chip select, async
- `copi`  in  1  controller out, peripheral in, async
- `cipo`  out  1  peripheral out, controller in
- `cipo_oe`  out  1  output enable for the `cipo` pad
- `regs`  out  `NUM_REGS*DATA_W`  flat register bus, reg *i* at `[i*DATA_W +: DATA_W]`
- `wr_strobe`  out  1  one-`clk` pulse when a write commits
- `wr_addr`  out  `ADDR_W`  address of the last committed write
- `frame_err`  out  1  one-`clk` pulse when a frame is aborted

## Operation
- Sync: 2-FF synchronisers on `ncs` and `copi`; 3 FFs on `sclk`. Rise = stage2 & ~stage3; fall = ~stage2 & stage3.
- Frame: `FRAME_W = 1+ADDR_W+DATA_W` bits, MSB first, sampled on `sclk` rise. Bit 0 is R/W# (1 = write), then the address, then the data.
- FSM:
  - IDLE: synced `ncs` low → SHIFT, with bit count 0 and shift register cleared.
  - SHIFT: on each rise, shift `copi` in and increment the count. On the rise with count == `FRAME_W-1`, the frame completes using the incoming bit, not the stale shift value → DONE.
  - DONE: further edges are ignored until `ncs` goes high → IDLE.
- Write commit (on frame completion, W=1, addr < `NUM_REGS`): write data to reg[addr], pulse `wr_strobe`, load `wr_addr`. If addr ≥ `NUM_REGS`, the frame is dropped silently and there is no strobe.
- Read (R/W#=0, `SPI_READBACK_EN` defined):
  - On the rise that captures the last address bit, load the output shifter with reg[addr], or 0 if out of range.
  - `cipo` = shifter MSB. The shifter shifts left on each subsequent fall.
  - A read frame never modifies registers.
- `cipo_oe` = 1 whenever synced `ncs` is low and the state is not IDLE. `cipo` = 0 when `cipo_oe` = 0.
- `ncs` rising while in SHIFT with count ≠ 0: discard the frame, pulse `frame_err`, go to IDLE. `ncs` high in DONE or with count 0 produces no error.
- `rst_n` low at any time: all state cleared immediately and the frame is lost.

## Timing
- Reset values: `regs` = 0, `cipo` = 0, `cipo_oe` = 0, `wr_strobe` = 0, `wr_addr` = 0, `frame_err` = 0, FSM = IDLE.
- Edge detect latency: 3 `clk` cycles after the pin edge. Register update and `wr_strobe` occur in the `clk` cycle after the detecting cycle. `regs` are stable otherwise.
- `wr_strobe` and `frame_err` are exactly 1 cycle wide and never asserted together.
- `sclk` high and low phases must each be ≥ 4 `clk` periods. The `ncs` setup and hold to the first and last `sclk` edge must each be ≥ 4 `clk` periods.
- `cipo` read data bit *k* is valid from the fall preceding controller rise *k*, or from the load for the data MSB, plus 1 `clk`.

## Configuration
- `SPI_READBACK_EN` defined: the read path, output shifter and `cipo_oe` logic are built as above.
- Not defined:
  - `cipo` and `cipo_oe` are tied to 0 and no output shifter is instantiated.
  - Read frames are clocked through in full but are otherwise ignored: no register change, no strobe, no error.

## Test plan
- Reset: hold `rst_n`=0, toggle SPI pins → all outputs 0. Release reset → `regs` = 0.
- Write: default params, frame W=1, addr 0x04, data 0xA5 → reg4 = 0xA5, one `wr_strobe`, `wr_addr` = 4, other regs unchanged.
- Out-of-range write: addr 0x05, data 0xFF → no register change, no `wr_strobe`, no `frame_err`.
- Readback (`SPI_READBACK_EN`): write reg2 = 0x3C, then a read frame to addr 2 → controller captures 0x3C on `cipo`, `regs` unchanged. A read of addr 0x10 returns 0x00.
- Abort: raise `ncs` after 10 bits of a write to reg1 → one `frame_err`, reg1 unchanged. The next full frame writing 0x11 to reg1 succeeds.
- Param sweep: `NUM_REGS`=16, `DATA_W`=16, `ADDR_W`=4. Write 0xBEEF to reg15 → `regs[255:240]` = 0xBEEF. Send 30 extra `sclk` cycles before `ncs` rises → no further change.
